// File: rtl/rv32i_pkg.sv
// Shared constants and FSM encoding for the rv32i run controller.
// Imported by the controller and its counters.
package rv32i_pkg;

  localparam int          RV_XLEN   = 32;
  localparam logic [31:0] RV_TOHOST = 32'h0000_1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rv32i_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != '1)) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Run controller: sequences core reset, bounds the run with a
// watchdog and ends it on a store to the TOHOST address.
module rv32i_run_ctrl
  import rv32i_pkg::*;
#(
  parameter int              XLEN        = RV_XLEN,
  parameter int              CNT_W       = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              MAX_CYCLES  = 10000,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(RV_TOHOST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             core_rst_n,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  input  logic             retire,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WD_ON    = (MAX_CYCLES != 0);

  state_e          state_q, state_d;
  logic [RW-1:0]   rst_ctr_q, rst_ctr_d;
  logic            pass_q, pass_d;
  logic            to_q, to_d;
  logic [XLEN-1:0] exit_q, exit_d;
  logic            cnt_clr;
  logic            cyc_en;
  logic            ret_en;

  always_comb begin
    state_d   = state_q;
    rst_ctr_d = rst_ctr_q;
    pass_d    = pass_q;
    to_d      = to_q;
    exit_d    = exit_q;
    cnt_clr   = 1'b0;
    cyc_en    = 1'b0;
    ret_en    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RST;
          rst_ctr_d = RST_LOAD;
          cnt_clr   = 1'b1;
          pass_d    = 1'b0;
          to_d      = 1'b0;
          exit_d    = '0;
        end
      end
      S_RST: begin
        if (rst_ctr_q == '0) begin
          state_d = S_RUN;
        end else begin
          rst_ctr_d = rst_ctr_q - RW'(1);
        end
      end
      S_RUN: begin
        cyc_en = 1'b1;
        ret_en = retire;
        // A TOHOST store wins over a watchdog expiry in the same cycle
        if (st_valid && (st_addr == TOHOST_ADDR)) begin
          exit_d  = st_data;
          pass_d  = (st_data == XLEN'(1));
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (WD_ON && (cycle_cnt == WD_LAST)) begin
          exit_d  = '0;
          pass_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rst_ctr_q <= '0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
      exit_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_ctr_q <= rst_ctr_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
      exit_q    <= exit_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cyc_en),
    .clr   (cnt_clr),
    .q     (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ret_en),
    .clr   (cnt_clr),
    .q     (instret_cnt)
  );

  assign core_rst_n = (state_q == S_RUN);
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign timeout    = to_q;
  assign exit_code  = exit_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Bench for rv32i_run_ctrl: a 32-bit instance with a 50-cycle
// watchdog and a 4-bit instance with the watchdog disabled.
module tb_rv32i_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic        retire;

  logic        core_rst_n_a, running_a, done_a, pass_a, timeout_a;
  logic [31:0] exit_a, cyc_a, inst_a;
  logic        core_rst_n_b, running_b, done_b, pass_b, timeout_b;
  logic [31:0] exit_b;
  logic [3:0]  cyc_b, inst_b;

  int vec = 0;
  int err = 0;

  typedef struct {
    logic        pass;
    logic        to;
    logic [31:0] ec;
    logic [31:0] cyc;
    logic [31:0] inst;
  } exp_t;

  exp_t sba[$];
  exp_t sbb[$];

  rv32i_run_ctrl #(
    .XLEN(32), .CNT_W(32), .RST_CYCLES(4),
    .MAX_CYCLES(50), .TOHOST_ADDR(32'h0000_1000)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .core_rst_n(core_rst_n_a), .st_valid(st_valid),
    .st_addr(st_addr), .st_data(st_data), .retire(retire),
    .running(running_a), .done(done_a), .pass(pass_a),
    .timeout(timeout_a), .exit_code(exit_a),
    .cycle_cnt(cyc_a), .instret_cnt(inst_a)
  );

  rv32i_run_ctrl #(
    .XLEN(32), .CNT_W(4), .RST_CYCLES(4),
    .MAX_CYCLES(0), .TOHOST_ADDR(32'h0000_1000)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .core_rst_n(core_rst_n_b), .st_valid(st_valid),
    .st_addr(st_addr), .st_data(st_data), .retire(retire),
    .running(running_b), .done(done_b), .pass(pass_b),
    .timeout(timeout_b), .exit_code(exit_b),
    .cycle_cnt(cyc_b), .instret_cnt(inst_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1);
  end

  // Scoreboard: compare each rising done against the queued expectation
  logic        prev_a = 1'b0, prev_b = 1'b0;
  exp_t        e;
  logic        a_pass, a_to;
  logic [31:0] a_ec, a_cyc, a_inst;
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic dn, pv;
      dn = (b == 0) ? (done_a === 1'b1) : (done_b === 1'b1);
      pv = (b == 0) ? prev_a : prev_b;
      if (dn && !pv) begin
        vec++;
        if ((b == 0 && sba.size() == 0) || (b == 1 && sbb.size() == 0)) begin
          err++;
          $display("FAIL sb_unexpected_done dut=%0d: done=1 required=no run ending", b);
        end else begin
          e      = (b == 0) ? sba.pop_front() : sbb.pop_front();
          a_pass = (b == 0) ? pass_a : pass_b;
          a_to   = (b == 0) ? timeout_a : timeout_b;
          a_ec   = (b == 0) ? exit_a : exit_b;
          a_cyc  = (b == 0) ? cyc_a : {28'd0, cyc_b};
          a_inst = (b == 0) ? inst_a : {28'd0, inst_b};
          if ({a_pass, a_to} !== {e.pass, e.to}) begin
            err++;
            $display("FAIL sb_flags dut=%0d: pass/timeout=%b%b required=%b%b",
                     b, a_pass, a_to, e.pass, e.to);
          end
          vec++;
          if (a_ec !== e.ec) begin
            err++;
            $display("FAIL sb_exit_code dut=%0d: got=%h required=%h", b, a_ec, e.ec);
          end
          vec++;
          if (a_cyc !== e.cyc) begin
            err++;
            $display("FAIL sb_cycle_cnt dut=%0d: got=%0d required=%0d", b, a_cyc, e.cyc);
          end
          vec++;
          if (a_inst !== e.inst) begin
            err++;
            $display("FAIL sb_instret_cnt dut=%0d: got=%0d required=%0d", b, a_inst, e.inst);
          end
        end
      end
    end
    prev_a = (done_a === 1'b1);
    prev_b = (done_b === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_data  = 'x;
    retire   = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    retire   = r;
    tick();
  endtask

  task automatic start_run(input bit b);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    idle_in();
    repeat (2) tick();
    vec++;
    if ({core_rst_n_a, running_a, done_a, pass_a, timeout_a} !== 5'b0) begin
      err++;
      $display("FAIL reset_flags: got=%b required=00000",
               {core_rst_n_a, running_a, done_a, pass_a, timeout_a});
    end
    vec++;
    if ({exit_a, cyc_a, inst_a} !== 96'd0) begin
      err++;
      $display("FAIL reset_values: exit=%h cyc=%0d inst=%0d required=0",
               exit_a, cyc_a, inst_a);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_core_reset_seq();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if ({core_rst_n_a, running_a} !== 2'b00) begin
        err++;
        $display("FAIL rst_hold[%0d]: core_rst_n/running=%b required=00",
                 i, {core_rst_n_a, running_a});
      end
      tick();
    end
    vec++;
    if ({core_rst_n_a, running_a} !== 2'b11 || cyc_a !== 32'd0) begin
      err++;
      $display("FAIL rst_release: core_rst_n/running=%b cyc=%0d required=11 cyc=0",
               {core_rst_n_a, running_a}, cyc_a);
    end
  endtask

  task automatic test_pass();
    for (int c = 1; c <= 19; c++) begin
      drive(1'b0, 32'h0, 'x, (c % 2 == 0) && (c <= 12));
    end
    vec++;
    if (running_a !== 1'b1 || cyc_a !== 32'd19 || inst_a !== 32'd6) begin
      err++;
      $display("FAIL pass_midrun: running=%b cyc=%0d inst=%0d required=1 19 6",
               running_a, cyc_a, inst_a);
    end
    sba.push_back('{pass: 1'b1, to: 1'b0, ec: 32'h1, cyc: 32'd20, inst: 32'd7});
    drive(1'b1, 32'h1000, 32'h1, 1'b1);
    idle_in();
    vec++;
    if ({done_a, core_rst_n_a, running_a} !== 3'b100) begin
      err++;
      $display("FAIL pass_done: done/core_rst_n/running=%b required=100",
               {done_a, core_rst_n_a, running_a});
    end
    repeat (3) drive(1'b1, 32'h1000, 32'h3, 1'b1);
    idle_in();
    tick();
    vec++;
    if (cyc_a !== 32'd20 || inst_a !== 32'd7 || exit_a !== 32'h1 || done_a !== 1'b1) begin
      err++;
      $display("FAIL done_hold: cyc=%0d inst=%0d exit=%h done=%b required=20 7 1 1",
               cyc_a, inst_a, exit_a, done_a);
    end
  endtask

  task automatic test_fail_code();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vec++;
    if ({done_a, pass_a} !== 2'b00 || cyc_a !== 32'd0 ||
        inst_a !== 32'd0 || exit_a !== 32'd0) begin
      err++;
      $display("FAIL restart_clear: done/pass=%b cyc=%0d inst=%0d exit=%h required=0",
               {done_a, pass_a}, cyc_a, inst_a, exit_a);
    end
    repeat (4) tick();
    for (int c = 1; c <= 4; c++) drive(1'b1, 32'h1004, 32'h1, 1'b1);
    vec++;
    if (running_a !== 1'b1 || exit_a !== 32'd0) begin
      err++;
      $display("FAIL other_addr: running=%b exit=%h required=1 0", running_a, exit_a);
    end
    sba.push_back('{pass: 1'b0, to: 1'b0, ec: 32'h2A, cyc: 32'd5, inst: 32'd4});
    drive(1'b1, 32'h1000, 32'h2A, 1'b0);
    idle_in();
    vec++;
    if (done_a !== 1'b1) begin
      err++;
      $display("FAIL fail_done: done=%b required=1", done_a);
    end
  endtask

  task automatic test_watchdog();
    start_run(1'b0);
    for (int c = 1; c <= 49; c++) drive(1'b0, 32'h0, 'x, 1'b1);
    vec++;
    if (running_a !== 1'b1 || cyc_a !== 32'd49) begin
      err++;
      $display("FAIL wd_early: running=%b cyc=%0d required=1 49", running_a, cyc_a);
    end
    sba.push_back('{pass: 1'b0, to: 1'b1, ec: 32'h0, cyc: 32'd50, inst: 32'd50});
    drive(1'b0, 32'h0, 'x, 1'b1);
    idle_in();
    vec++;
    if (done_a !== 1'b1) begin
      err++;
      $display("FAIL wd_done: done=%b required=1", done_a);
    end
    start_run(1'b0);
    for (int c = 1; c <= 49; c++) drive(1'b0, 32'h0, 'x, 1'b0);
    sba.push_back('{pass: 1'b1, to: 1'b0, ec: 32'h1, cyc: 32'd50, inst: 32'd0});
    drive(1'b1, 32'h1000, 32'h1, 1'b0);
    idle_in();
    vec++;
    if ({done_a, timeout_a} !== 2'b10) begin
      err++;
      $display("FAIL wd_priority: done/timeout=%b required=10", {done_a, timeout_a});
    end
  endtask

  task automatic test_start_and_async_reset();
    start_run(1'b0);
    repeat (3) drive(1'b0, 32'h0, 'x, 1'b0);
    start_a = 1'b1;
    drive(1'b0, 32'h0, 'x, 1'b0);
    start_a = 1'b0;
    repeat (2) drive(1'b0, 32'h0, 'x, 1'b0);
    vec++;
    if (running_a !== 1'b1 || cyc_a !== 32'd6) begin
      err++;
      $display("FAIL start_in_run: running=%b cyc=%0d required=1 6", running_a, cyc_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({core_rst_n_a, running_a, done_a, pass_a, timeout_a} !== 5'b0 ||
        cyc_a !== 32'd0 || exit_a !== 32'd0) begin
      err++;
      $display("FAIL async_reset: flags=%b cyc=%0d exit=%h required=0",
               {core_rst_n_a, running_a, done_a, pass_a, timeout_a}, cyc_a, exit_a);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_run(1'b0);
    vec++;
    if (running_a !== 1'b1) begin
      err++;
      $display("FAIL run_after_reset: running=%b required=1", running_a);
    end
    sba.push_back('{pass: 1'b0, to: 1'b0, ec: 32'h7, cyc: 32'd1, inst: 32'd0});
    drive(1'b1, 32'h1000, 32'h7, 1'b0);
    idle_in();
    tick();
  endtask

  task automatic test_saturate();
    start_run(1'b1);
    for (int c = 1; c <= 20; c++) drive(1'b0, 32'h0, 'x, 1'b1);
    vec++;
    if (running_b !== 1'b1 || cyc_b !== 4'hF || inst_b !== 4'hF) begin
      err++;
      $display("FAIL saturate: running=%b cyc=%0d inst=%0d required=1 15 15",
               running_b, cyc_b, inst_b);
    end
    sbb.push_back('{pass: 1'b0, to: 1'b0, ec: 32'h5, cyc: 32'd15, inst: 32'd15});
    drive(1'b1, 32'h1000, 32'h5, 1'b1);
    idle_in();
    vec++;
    if (done_b !== 1'b1) begin
      err++;
      $display("FAIL sat_done: done=%b required=1", done_b);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_core_reset_seq();
    test_pass();
    test_fail_code();
    test_watchdog();
    test_start_and_async_reset();
    test_saturate();
    repeat (2) tick();
    vec++;
    if (sba.size() != 0 || sbb.size() != 0) begin
      err++;
      $display("FAIL sb_leftover: pending a=%0d b=%0d required=0",
               sba.size(), sbb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
